nts_receiver: RTL and testbench
===============================

Name: nts_receiver

Overview:
- MAC RX side counterpart of the TX extractor.
- Captures 64-bit XGMII-style MAC RX words into a ring of packet buffers held in one bram_dp2w.
- Validates frame status and presents each good frame to the NTS engine through the packet-available / FIFO-read interface that the engine already consumes.
- Byte alignment: last-word bytes arrive LSB-aligned from the MAC and are handed to the engine MSB-aligned.

Parameters:
- ADDR_WIDTH, 8, log2 words per buffer. Max frame is 2^ADDR_WIDTH-1 words.
- BUFFER_SELECT_WIDTH, 2, log2 buffer count. BUFFERS = 1<<BUFFER_SELECT_WIDTH.

Ports:
- i_areset  in  1  async reset, active-high
- i_clk  in  1  clock
- i_mac_rx_data_valid  in  8  byte-lane valid mask, bit0 = lane [7:0]
- i_mac_rx_data  in  64  RX word
- i_mac_rx_good_frame  in  1  status strobe: frame good
- i_mac_rx_bad_frame  in  1  status strobe: frame bad
- o_engine_packet_available  out  1  a loaded buffer is presented
- i_engine_packet_read  in  1  pulse: engine releases presented buffer
- o_engine_fifo_empty  out  1  all words of presented packet read
- i_engine_fifo_rd_en  in  1  read one word
- o_engine_fifo_rd_data  out  64  word, valid one cycle after rd_en
- o_engine_bytes_last_word  out  4  valid bytes in last word, 1..8
- o_frames_received  out  32  good frames committed, saturating
- o_frames_dropped  out  32  frames discarded for any reason, saturating

Behaviour:
- Reset: i_areset is asynchronous, active-high; clock is i_clk.
  - All outputs are 0 on reset, except o_engine_fifo_empty = 1.
  - Selectors, pointers and counters are cleared.
- Reset sweep:
  - After reset release the block is in STATE_RESET. It clears per-buffer length, lwdv and state (UNUSED), one buffer per cycle.
  - It enters STATE_NORMAL after BUFFERS cycles.
  - MAC input during the sweep is ignored. A frame in flight at sweep end is dropped; see DROP below.
- Per-buffer state: UNUSED -> WRITING -> LOADED -> READING -> UNUSED. There are two selectors, wr_sel and rd_sel, both incrementing modulo BUFFERS.
- MAC FSM states: IDLE, WRITE, AWAIT_STATUS, DROP.
  - IDLE, data_valid != 0:
    - If buffer[wr_sel] is UNUSED: write the word at address 0 and go to WRITE.
    - Otherwise (all buffers busy): go to DROP.
  - WRITE, data_valid = 8'hff: write the next word. Address reaching 2^ADDR_WIDTH-1 is an overflow: buffer returns to UNUSED, go to DROP.
  - WRITE, data_valid = 2^n-1 with n in 1..7 (partial last word):
    - Write {data[8n-1:0], (64-8n) zeros}.
    - Record lwdv = n.
    - Go to AWAIT_STATUS.
  - WRITE, data_valid = 0: the previous word was full, so lwdv = 8.
    - If good: commit.
    - If bad: discard.
    - Otherwise: go to AWAIT_STATUS.
  - Any non-contiguous mask, or a nonzero word in AWAIT_STATUS: buffer returns to UNUSED, go to DROP.
  - AWAIT_STATUS:
    - good: commit.
    - bad: discard and go to IDLE.
  - good and bad asserted together count as bad.
  - Commit:
    - Store the word count as length, set buffer LOADED, increment wr_sel, increment o_frames_received.
    - Go to IDLE.
  - Discard: buffer returns to UNUSED, wr_sel unchanged, increment o_frames_dropped.
  - DROP:
    - Wait for a good or bad strobe, then increment o_frames_dropped and go to IDLE.
    - If the strobe arrives on the same cycle DROP is entered (e.g. full-word frame with no buffers), count it then and go to IDLE.
  - A frame of exactly one partial word is legal.
- Engine side:
  - o_engine_packet_available is 1 while buffer[rd_sel] is LOADED or READING.
    - The first i_engine_fifo_rd_en moves the buffer to READING.
  - Read pointer rd_ptr resets to 0 on each new buffer.
  - On rd_en with rd_ptr < length: issue the BRAM read and increment rd_ptr. Data appears on o_engine_fifo_rd_data the next cycle and is held until the next read.
  - o_engine_fifo_empty = !available || rd_ptr == length.
  - rd_en while empty is ignored and rd_ptr does not move.
  - o_engine_bytes_last_word = lwdv of buffer[rd_sel] while available, else 0.
  - On i_engine_packet_read while available:
    - Buffer returns to UNUSED and rd_sel increments.
    - available drops the next cycle.
    - It re-asserts the cycle after that if the next buffer is LOADED.
  - i_engine_packet_read while not available is ignored.
- Simultaneous events:
  - A MAC commit to buffer k and an engine release of buffer j != k in the same cycle both take effect.
  - A release freeing the buffer the MAC wants in that cycle is seen by IDLE on the following cycle. No same-cycle reuse.
- Counters saturate at 32'hffff_ffff.

Test Plan:
1. Reset, then a 3-word frame: ff,ff,07, good strobe next cycle.
   - available=1, bytes_last_word=3.
   - Three rd_en return the words; the 3rd is {data[23:0],40'h0}.
   - Then empty=1. packet_read drops available. frames_received=1.
2. 2-word full frame with good strobe in the data_valid=0 cycle.
   - bytes_last_word=8, both words returned unchanged.
3. Bad strobe on a 2-word frame.
   - available stays 0, frames_dropped=1.
   - The next good frame lands in the same buffer and is delivered.
4. Five back-to-back good frames with the engine stalled (BUFFERS=4).
   - First four are delivered in order after reads resume.
   - Fifth is dropped, frames_dropped=1.
5. 256-word ff frame: overflow.
   - Dropped at the strobe, no available.
   - The next 1-word 01 frame is delivered with bytes_last_word=1.
6. Assert i_areset mid-frame and mid-engine-read.
   - Outputs go to reset values immediately.
   - After the BUFFERS-cycle sweep, a new frame is delivered normally.

Source files
------------

// File: rtl/nts_receiver.sv
// nts_receiver: captures MAC RX words into a ring of packet buffers and
// presents each good frame to the NTS engine as a packet/FIFO interface.
`timescale 1ns/1ps
module nts_receiver #(
  parameter int ADDR_WIDTH          = 8,
  parameter int BUFFER_SELECT_WIDTH = 2
) (
  input  logic        i_areset,
  input  logic        i_clk,
  input  logic [7:0]  i_mac_rx_data_valid,
  input  logic [63:0] i_mac_rx_data,
  input  logic        i_mac_rx_good_frame,
  input  logic        i_mac_rx_bad_frame,
  output logic        o_engine_packet_available,
  input  logic        i_engine_packet_read,
  output logic        o_engine_fifo_empty,
  input  logic        i_engine_fifo_rd_en,
  output logic [63:0] o_engine_fifo_rd_data,
  output logic [3:0]  o_engine_bytes_last_word,
  output logic [31:0] o_frames_received,
  output logic [31:0] o_frames_dropped
);

  localparam int BUFFERS   = 1 << BUFFER_SELECT_WIDTH;
  localparam int MEM_AW    = BUFFER_SELECT_WIDTH + ADDR_WIDTH;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam logic [ADDR_WIDTH-1:0]          ADDR_MAX = '1;
  localparam logic [BUFFER_SELECT_WIDTH-1:0] SEL_MAX  = '1;

  typedef enum logic {STATE_RESET, STATE_NORMAL} mode_t;
  typedef enum logic [1:0] {MAC_IDLE, MAC_WRITE, MAC_AWAIT_STATUS, MAC_DROP} mac_state_t;
  typedef enum logic [1:0] {BUF_UNUSED, BUF_WRITING, BUF_LOADED, BUF_READING} buf_state_t;

  mode_t                          r_mode;
  logic [BUFFER_SELECT_WIDTH-1:0] r_sweep;
  logic                           r_rx_busy;
  mac_state_t                     r_mac_state;
  mac_state_t                     w_next_mac;
  logic [BUFFER_SELECT_WIDTH-1:0] r_wr_sel;
  logic [ADDR_WIDTH-1:0]          r_wr_addr;
  logic [3:0]                     r_cur_lwdv;
  logic [BUFFER_SELECT_WIDTH-1:0] r_rd_sel;
  logic [ADDR_WIDTH-1:0]          r_rd_ptr;
  logic                           r_release_gap;
  logic [63:0]                    r_rd_data;
  logic [31:0]                    r_frames_received;
  logic [31:0]                    r_frames_dropped;

  buf_state_t                     r_buf_state  [0:BUFFERS-1];
  logic [ADDR_WIDTH-1:0]          r_buf_length [0:BUFFERS-1];
  logic [3:0]                     r_buf_lwdv   [0:BUFFERS-1];
  logic [63:0]                    r_mem        [0:MEM_DEPTH-1];

  logic [3:0]            w_nbytes;
  logic [3:0]            w_pad;
  logic [6:0]            w_shamt;
  logic [63:0]           w_write_data;
  logic                  w_valid_any, w_good, w_strobe;
  logic                  w_mem_we, w_claim, w_abort, w_commit, w_discard;
  logic                  w_drop_count, w_to_drop, w_lwdv_load;
  logic [3:0]            w_lwdv_value, w_commit_lwdv;
  logic [ADDR_WIDTH-1:0] w_wr_lo, w_wr_addr_next;
  logic                  w_avail, w_empty, w_rd_fire, w_release;

  // Decode the lane mask into a byte count (0 means not a contiguous LSB mask)
  // and move the valid bytes of a partial word up to the MSB end.
  always_comb begin
    case (i_mac_rx_data_valid)
      8'h01:   w_nbytes = 4'd1;
      8'h03:   w_nbytes = 4'd2;
      8'h07:   w_nbytes = 4'd3;
      8'h0f:   w_nbytes = 4'd4;
      8'h1f:   w_nbytes = 4'd5;
      8'h3f:   w_nbytes = 4'd6;
      8'h7f:   w_nbytes = 4'd7;
      8'hff:   w_nbytes = 4'd8;
      default: w_nbytes = 4'd0;
    endcase
    w_pad        = 4'd8 - w_nbytes;
    w_shamt      = {w_pad, 3'b000};
    w_write_data = i_mac_rx_data << w_shamt;
    w_valid_any  = (i_mac_rx_data_valid != 8'h00);
    w_good       = i_mac_rx_good_frame && !i_mac_rx_bad_frame;
    w_strobe     = i_mac_rx_good_frame || i_mac_rx_bad_frame;
  end

  // MAC next-state and action decode; a frame already running when the
  // sweep finishes is sent to DROP so its status strobe gets counted.
  always_comb begin
    w_next_mac     = r_mac_state;
    w_mem_we       = 1'b0;
    w_claim        = 1'b0;
    w_abort        = 1'b0;
    w_commit       = 1'b0;
    w_discard      = 1'b0;
    w_drop_count   = 1'b0;
    w_to_drop      = 1'b0;
    w_lwdv_load    = 1'b0;
    w_lwdv_value   = w_nbytes;
    w_wr_lo        = r_wr_addr;
    w_wr_addr_next = r_wr_addr;
    w_commit_lwdv  = (r_mac_state == MAC_WRITE) ? 4'd8 : r_cur_lwdv;
    if (r_mode == STATE_RESET) begin
      w_next_mac = MAC_IDLE;
      if (r_sweep == SEL_MAX && (r_rx_busy || w_valid_any))
        w_to_drop = 1'b1;
    end else begin
      case (r_mac_state)
        MAC_IDLE: begin
          if (w_valid_any) begin
            if (w_nbytes == 4'd0 || r_buf_state[r_wr_sel] != BUF_UNUSED) begin
              w_to_drop = 1'b1;
            end else begin
              w_mem_we       = 1'b1;
              w_claim        = 1'b1;
              w_wr_lo        = '0;
              w_wr_addr_next = ADDR_WIDTH'(1);
              if (w_nbytes == 4'd8) begin
                w_next_mac = MAC_WRITE;
              end else begin
                w_lwdv_load = 1'b1;
                w_next_mac  = MAC_AWAIT_STATUS;
              end
            end
          end
        end
        MAC_WRITE: begin
          if (!w_valid_any) begin
            if (i_mac_rx_bad_frame) begin
              w_discard  = 1'b1;
              w_next_mac = MAC_IDLE;
            end else if (w_good) begin
              w_commit   = 1'b1;
              w_next_mac = MAC_IDLE;
            end else begin
              w_lwdv_load  = 1'b1;
              w_lwdv_value = 4'd8;
              w_next_mac   = MAC_AWAIT_STATUS;
            end
          end else if (w_nbytes == 4'd0 || r_wr_addr == ADDR_MAX) begin
            w_abort   = 1'b1;
            w_to_drop = 1'b1;
          end else begin
            w_mem_we       = 1'b1;
            w_wr_addr_next = r_wr_addr + 1'b1;
            if (w_nbytes != 4'd8) begin
              w_lwdv_load = 1'b1;
              w_next_mac  = MAC_AWAIT_STATUS;
            end
          end
        end
        MAC_AWAIT_STATUS: begin
          if (w_valid_any) begin
            w_abort   = 1'b1;
            w_to_drop = 1'b1;
          end else if (i_mac_rx_bad_frame) begin
            w_discard  = 1'b1;
            w_next_mac = MAC_IDLE;
          end else if (w_good) begin
            w_commit   = 1'b1;
            w_next_mac = MAC_IDLE;
          end
        end
        MAC_DROP: begin
          if (w_strobe) begin
            w_drop_count = 1'b1;
            w_next_mac   = MAC_IDLE;
          end
        end
        default: w_next_mac = MAC_IDLE;
      endcase
    end
    if (w_to_drop) begin
      if (w_strobe) begin
        w_drop_count = 1'b1;
        w_next_mac   = MAC_IDLE;
      end else begin
        w_next_mac = MAC_DROP;
      end
    end
  end

  // MAC state register.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) r_mac_state <= MAC_IDLE;
    else          r_mac_state <= w_next_mac;
  end

  // Engine-facing outputs; availability is held off for one cycle after a release.
  always_comb begin
    w_avail   = (r_mode == STATE_NORMAL) && !r_release_gap &&
                (r_buf_state[r_rd_sel] == BUF_LOADED || r_buf_state[r_rd_sel] == BUF_READING);
    w_empty   = !w_avail || (r_rd_ptr == r_buf_length[r_rd_sel]);
    w_rd_fire = i_engine_fifo_rd_en && !w_empty;
    w_release = i_engine_packet_read && w_avail;
    o_engine_packet_available = w_avail;
    o_engine_fifo_empty       = w_empty;
    o_engine_bytes_last_word  = w_avail ? r_buf_lwdv[r_rd_sel] : 4'd0;
    o_engine_fifo_rd_data     = r_rd_data;
    o_frames_received         = r_frames_received;
    o_frames_dropped          = r_frames_dropped;
  end

  // Control registers: sweep, selectors, pointers, read data and counters.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_mode            <= STATE_RESET;
      r_sweep           <= '0;
      r_rx_busy         <= 1'b0;
      r_wr_sel          <= '0;
      r_wr_addr         <= '0;
      r_cur_lwdv        <= '0;
      r_rd_sel          <= '0;
      r_rd_ptr          <= '0;
      r_release_gap     <= 1'b0;
      r_rd_data         <= '0;
      r_frames_received <= '0;
      r_frames_dropped  <= '0;
    end else begin
      r_rx_busy <= (r_rx_busy || w_valid_any) && !w_strobe;
      if (r_mode == STATE_RESET) begin
        r_sweep <= r_sweep + 1'b1;
        if (r_sweep == SEL_MAX) r_mode <= STATE_NORMAL;
      end
      r_wr_addr <= w_wr_addr_next;
      if (w_lwdv_load) r_cur_lwdv <= w_lwdv_value;
      if (w_commit) r_wr_sel <= r_wr_sel + 1'b1;
      if (w_commit && r_frames_received != 32'hffff_ffff)
        r_frames_received <= r_frames_received + 1'b1;
      if ((w_drop_count || w_discard) && r_frames_dropped != 32'hffff_ffff)
        r_frames_dropped <= r_frames_dropped + 1'b1;
      r_release_gap <= w_release;
      if (w_rd_fire) r_rd_data <= r_mem[{r_rd_sel, r_rd_ptr}];
      if (w_release) begin
        r_rd_sel <= r_rd_sel + 1'b1;
        r_rd_ptr <= '0;
      end else if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Per-buffer bookkeeping: the sweep clears one buffer per cycle, then the
  // MAC and engine each act on their own buffer, which are always distinct.
  always_ff @(posedge i_clk) begin
    if (r_mode == STATE_RESET) begin
      r_buf_state[r_sweep]  <= BUF_UNUSED;
      r_buf_length[r_sweep] <= '0;
      r_buf_lwdv[r_sweep]   <= '0;
    end else begin
      if (w_claim) r_buf_state[r_wr_sel] <= BUF_WRITING;
      if (w_abort || w_discard) r_buf_state[r_wr_sel] <= BUF_UNUSED;
      if (w_commit) begin
        r_buf_state[r_wr_sel]  <= BUF_LOADED;
        r_buf_length[r_wr_sel] <= r_wr_addr;
        r_buf_lwdv[r_wr_sel]   <= w_commit_lwdv;
      end
      if (w_release)
        r_buf_state[r_rd_sel] <= BUF_UNUSED;
      else if (w_rd_fire && r_buf_state[r_rd_sel] == BUF_LOADED)
        r_buf_state[r_rd_sel] <= BUF_READING;
    end
  end

  // Packet storage write port.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[{r_wr_sel, w_wr_lo}] <= w_write_data;
  end

endmodule

// File: tb/tb_nts_receiver.sv
// tb_nts_receiver: directed and randomized frames against a queue-based
// model of delivered packets and drop/receive counts.
`timescale 1ns/1ps
module tb_nts_receiver;

  localparam int BUFFERS = 4;

  logic        i_areset, i_clk;
  logic [7:0]  i_mac_rx_data_valid;
  logic [63:0] i_mac_rx_data;
  logic        i_mac_rx_good_frame, i_mac_rx_bad_frame;
  logic        o_engine_packet_available;
  logic        i_engine_packet_read;
  logic        o_engine_fifo_empty;
  logic        i_engine_fifo_rd_en;
  logic [63:0] o_engine_fifo_rd_data;
  logic [3:0]  o_engine_bytes_last_word;
  logic [31:0] o_frames_received, o_frames_dropped;

  int testCount = 0;
  int failCount = 0;

  logic [63:0] expWords[$];
  int          expLen[$];
  int          expLwdv[$];
  int          expReceived = 0;
  int          expDropped  = 0;

  nts_receiver #(.ADDR_WIDTH(8), .BUFFER_SELECT_WIDTH(2)) dut (
    .i_areset                  (i_areset),
    .i_clk                     (i_clk),
    .i_mac_rx_data_valid       (i_mac_rx_data_valid),
    .i_mac_rx_data             (i_mac_rx_data),
    .i_mac_rx_good_frame       (i_mac_rx_good_frame),
    .i_mac_rx_bad_frame        (i_mac_rx_bad_frame),
    .o_engine_packet_available (o_engine_packet_available),
    .i_engine_packet_read      (i_engine_packet_read),
    .o_engine_fifo_empty       (o_engine_fifo_empty),
    .i_engine_fifo_rd_en       (i_engine_fifo_rd_en),
    .o_engine_fifo_rd_data     (o_engine_fifo_rd_data),
    .o_engine_bytes_last_word  (o_engine_bytes_last_word),
    .o_frames_received         (o_frames_received),
    .o_frames_dropped          (o_frames_dropped)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " frames_received"}, 64'(o_frames_received), 64'(expReceived));
    checkOutput({tag, " frames_dropped"}, 64'(o_frames_dropped), 64'(expDropped));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " available"}, 64'(o_engine_packet_available), 64'd0);
    checkOutput({tag, " empty"}, 64'(o_engine_fifo_empty), 64'd1);
    checkOutput({tag, " rd_data"}, o_engine_fifo_rd_data, 64'd0);
    checkOutput({tag, " bytes_last_word"}, 64'(o_engine_bytes_last_word), 64'd0);
    checkOutput({tag, " frames_received"}, 64'(o_frames_received), 64'd0);
    checkOutput({tag, " frames_dropped"}, 64'(o_frames_dropped), 64'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_mac_rx_data_valid = 8'h00;
      i_mac_rx_data       = 64'd0;
      i_mac_rx_good_frame = 1'b0;
      i_mac_rx_bad_frame  = 1'b0;
    end
  endtask

  // Sends one frame: nWords words, the last carrying lastBytes bytes.
  // For full last words the status comes in the first empty cycle, or one
  // cycle later when statusLate is set. The model decides the fate.
  task automatic applyStimulus(input int nWords, input int lastBytes, input bit isGood, input bit statusLate);
    logic [63:0] d, stored, lowMask;
    bit accepted;
    accepted = isGood && (nWords <= 255) && (expLen.size() < BUFFERS);
    for (int i = 0; i < nWords; i++) begin
      @(negedge i_clk);
      d = {$urandom, $urandom};
      if (i == nWords - 1 && lastBytes < 8) begin
        lowMask = (64'd1 << (8 * lastBytes)) - 64'd1;
        stored  = (d & lowMask) << (8 * (8 - lastBytes));
        i_mac_rx_data_valid = 8'((1 << lastBytes) - 1);
      end else begin
        stored = d;
        i_mac_rx_data_valid = 8'hff;
      end
      i_mac_rx_data       = d;
      i_mac_rx_good_frame = 1'b0;
      i_mac_rx_bad_frame  = 1'b0;
      if (accepted) expWords.push_back(stored);
    end
    @(negedge i_clk);
    i_mac_rx_data_valid = 8'h00;
    i_mac_rx_data       = 64'd0;
    if (lastBytes == 8 && statusLate) @(negedge i_clk);
    i_mac_rx_good_frame = isGood ? 1'b1 : 1'($urandom_range(0, 1));
    i_mac_rx_bad_frame  = !isGood;
    @(negedge i_clk);
    i_mac_rx_good_frame = 1'b0;
    i_mac_rx_bad_frame  = 1'b0;
    if (accepted) begin
      expLen.push_back(nWords);
      expLwdv.push_back(lastBytes);
      expReceived++;
    end else begin
      expDropped++;
    end
  endtask

  // Reads one whole packet, checks every word, empty handling and release.
  task automatic drainOne(input string tag);
    int len, lwdv, budget;
    logic [63:0] lastWord;
    len  = expLen.pop_front();
    lwdv = expLwdv.pop_front();
    budget = 0;
    lastWord = 64'd0;
    while (!o_engine_packet_available && budget < 20) begin
      @(negedge i_clk);
      budget++;
    end
    checkOutput({tag, " available"}, 64'(o_engine_packet_available), 64'd1);
    checkOutput({tag, " bytes_last_word"}, 64'(o_engine_bytes_last_word), 64'(lwdv));
    i_engine_fifo_rd_en = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge i_clk);
      if (i == len - 1) i_engine_fifo_rd_en = 1'b0;
      lastWord = expWords.pop_front();
      checkOutput($sformatf("%s word%0d", tag, i), o_engine_fifo_rd_data, lastWord);
    end
    checkOutput({tag, " empty after reads"}, 64'(o_engine_fifo_empty), 64'd1);
    i_engine_fifo_rd_en = 1'b1;
    @(negedge i_clk);
    i_engine_fifo_rd_en = 1'b0;
    checkOutput({tag, " rd while empty holds data"}, o_engine_fifo_rd_data, lastWord);
    i_engine_packet_read = 1'b1;
    @(negedge i_clk);
    i_engine_packet_read = 1'b0;
    checkOutput({tag, " available drops after release"}, 64'(o_engine_packet_available), 64'd0);
  endtask

  initial begin
    i_areset             = 1'b1;
    i_mac_rx_data_valid  = 8'h00;
    i_mac_rx_data        = 64'd0;
    i_mac_rx_good_frame  = 1'b0;
    i_mac_rx_bad_frame   = 1'b0;
    i_engine_packet_read = 1'b0;
    i_engine_fifo_rd_en  = 1'b0;
    repeat (3) @(negedge i_clk);
    checkResetValues("reset");
    i_areset = 1'b0;
    idleCycles(BUFFERS + 2);

    // 3-word frame with a 3-byte last word, status one cycle later
    applyStimulus(3, 3, 1'b1, 1'b0);
    drainOne("t1");
    checkCounters("t1");

    // 2-word full frame, status in the first empty cycle
    applyStimulus(2, 8, 1'b1, 1'b0);
    drainOne("t2");

    // bad frame is discarded, the next good one is delivered
    applyStimulus(2, 8, 1'b0, 1'b0);
    checkOutput("t3 available after bad", 64'(o_engine_packet_available), 64'd0);
    checkCounters("t3");
    applyStimulus(2, 5, 1'b1, 1'b1);
    drainOne("t3");

    // five back-to-back frames with the engine stalled
    for (int i = 0; i < 5; i++) applyStimulus(2, $urandom_range(1, 8), 1'b1, 1'b0);
    checkCounters("t4");
    for (int i = 0; i < 4; i++) drainOne($sformatf("t4 pkt%0d", i));

    // 256-word frame overflows, then a 1-byte single-word frame
    applyStimulus(256, 8, 1'b1, 1'b0);
    checkOutput("t5 available after overflow", 64'(o_engine_packet_available), 64'd0);
    checkCounters("t5 overflow");
    applyStimulus(1, 1, 1'b1, 1'b0);
    drainOne("t5");
    checkCounters("t5");

    // randomized traffic with occasional engine reads
    for (int i = 0; i < 24; i++) begin
      applyStimulus($urandom_range(1, 6), $urandom_range(1, 8), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if (expLen.size() > 0 && $urandom_range(0, 2) == 0) drainOne($sformatf("rnd%0d", i));
    end
    while (expLen.size() > 0) drainOne("rnd tail");
    checkCounters("random");

    // reset mid-read and mid-frame
    applyStimulus(2, 8, 1'b1, 1'b0);
    @(negedge i_clk);
    i_engine_fifo_rd_en = 1'b1;
    @(negedge i_clk);
    i_engine_fifo_rd_en = 1'b0;
    i_mac_rx_data_valid = 8'hff;
    i_mac_rx_data       = {$urandom, $urandom};
    @(negedge i_clk);
    i_mac_rx_data = {$urandom, $urandom};
    #2;
    i_areset = 1'b1;
    #1;
    checkResetValues("t6 async reset");
    expWords.delete();
    expLen.delete();
    expLwdv.delete();
    expReceived = 0;
    expDropped  = 0;
    @(negedge i_clk);
    i_areset = 1'b0;
    // frame still running when the sweep ends must be dropped
    for (int i = 0; i < BUFFERS + 3; i++) begin
      i_mac_rx_data_valid = 8'hff;
      i_mac_rx_data       = {$urandom, $urandom};
      @(negedge i_clk);
    end
    i_mac_rx_data_valid = 8'h00;
    i_mac_rx_good_frame = 1'b1;
    @(negedge i_clk);
    i_mac_rx_good_frame = 1'b0;
    expDropped++;
    checkOutput("t6 available after in-flight", 64'(o_engine_packet_available), 64'd0);
    checkCounters("t6 in-flight");
    applyStimulus(3, 6, 1'b1, 1'b0);
    drainOne("t6");
    checkCounters("t6");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
